// File: rtl/serial_complement_32_if.sv
// -----------------------------------------------------------------------------
// serial_complement_32_if
//   Handshake and data bundle for the serial complement unit.
//
//   Signals (driven by master unless noted):
//     start  request; sampled by the unit only while busy=0
//     mode   0 = one's complement, 1 = two's complement
//     inp    WIDTH-bit operand
//     busy   (slave) operation in progress
//     done   (slave) one-cycle pulse when out/ovf update
//     out    (slave) last completed result
//     ovf    (slave) two's-complement overflow of last result
//
//   Modports:
//     master  requester side (ALU control / testbench)
//     slave   complement unit side
// -----------------------------------------------------------------------------
interface serial_complement_32_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] inp;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out;
    logic             ovf;

    modport master (
        output start,
        output mode,
        output inp,
        input  busy,
        input  done,
        input  out,
        input  ovf
    );

    modport slave (
        input  start,
        input  mode,
        input  inp,
        output busy,
        output done,
        output out,
        output ovf
    );
endinterface

// File: rtl/serial_complement_32.sv
// -----------------------------------------------------------------------------
// serial_complement_32
//   Multi-cycle one's / two's complement unit. Walks the operand LSB first,
//   DIGIT bits per clock, using a DIGIT-bit inverter and incrementer with a
//   carry flop instead of a full-width parallel negate.
//
//   Parameters:
//     WIDTH  operand/result width (default 32)
//     DIGIT  bits processed per clock; must divide WIDTH
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  synchronous active-low reset; aborts any operation silently
//     bus    serial_complement_32_if.slave
//              start/mode/inp in, busy/done/out/ovf out
//
//   Timing: start accepted at edge E0 (busy=0). Edges E1..E(WIDTH/DIGIT)
//   each process one digit; done is high in the cycle after the last one.
// -----------------------------------------------------------------------------
module serial_complement_32 #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input logic                  clk,
    input logic                  rst_n,
    serial_complement_32_if.slave bus
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_complement_32: DIGIT must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_opnd;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_mode;
    logic             r_msb;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;

    logic [DIGIT-1:0] w_digit;
    logic [DIGIT:0]   w_sum;
    logic [DIGIT-1:0] w_rdig;
    logic             w_cout;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_opnd_next;
    logic             w_ovf_next;

    // One digit of ~x + carry; carry starts at mode, so mode=0 is a plain invert.
    always_comb begin
        w_digit = r_opnd[DIGIT-1:0];
        w_sum   = {1'b0, ~w_digit} + {{DIGIT{1'b0}}, r_carry};
        w_rdig  = w_sum[DIGIT-1:0];
        w_cout  = w_sum[DIGIT];
    end

    // Result enters from the MSB side so after NDIG digits the first digit
    // has reached the LSB position.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign w_res_next  = w_rdig;
            assign w_opnd_next = '0;
        end else begin : g_multi
            assign w_res_next  = {w_rdig, r_res[WIDTH-1:DIGIT]};
            assign w_opnd_next = {{DIGIT{1'b0}}, r_opnd[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Negation overflows only for the most negative value: it is the one
    // operand whose sign bit survives negation (zero maps to zero).
    assign w_ovf_next = r_mode & r_msb & w_res_next[WIDTH-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_opnd  <= '0;
            r_res   <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_mode  <= 1'b0;
            r_msb   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_opnd  <= bus.inp;
                        r_mode  <= bus.mode;
                        r_carry <= bus.mode;
                        r_msb   <= bus.inp[WIDTH-1];
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_opnd  <= w_opnd_next;
                    r_res   <= w_res_next;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_out   <= w_res_next;
                        r_ovf   <= w_ovf_next;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.out  = r_out;
    assign bus.ovf  = r_ovf;

endmodule
